out_capture_serializer: RTL

OUT_CAPTURE_SERIALIZER -- requirements
Module: out_capture_serializer

---
 rtl/out_capture_serializer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/out_capture_serializer.sv
// Capture FIFO and serializer. Each captured output word is tagged with a free-running
// cycle count, then streamed out as one header chunk followed by the data chunks.
module out_capture_serializer #(
  parameter int          OUT_W   = 330,
  parameter int          CHUNK_W = 32,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] CNT_RST = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_valid,
  input  logic [OUT_W-1:0]   cap_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CHUNK_W-1:0] m_data,
  output logic               m_last,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);
  // state | meaning
  // IDLE  | nothing in flight, waiting for the FIFO to become non-empty
  // HDR   | presenting chunk 0 (cycle-count tag) of the head entry
  // DATA  | presenting data chunks 1..NCH-1 of the head entry
  localparam int NCH   = 1 + (OUT_W + CHUNK_W - 1) / CHUNK_W;
  localparam int IDX_W = $clog2(NCH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 32 + OUT_W;
  localparam int PAD_W = (NCH - 1) * CHUNK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               overflow_q;
  logic [15:0]        drop_q;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               full, empty, hs, pop, push, drop;
  logic [ENT_W-1:0]   head;
  logic [NCH*CHUNK_W-1:0] rec;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign m_valid = (state_q != IDLE);
  assign hs      = m_valid && m_ready;
  assign pop     = hs && (state_q == DATA) && (idx_q == LAST_IDX);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push    = cap_valid && (!full || pop);
  assign drop    = cap_valid && !push;
  assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  assign head = mem_q[rd_ptr_q];
  assign rec  = {PAD_W'(head[OUT_W-1:0]), CHUNK_W'(head[ENT_W-1:OUT_W])};

  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

  always_comb begin
    m_data = '0;
    m_last = 1'b0;
    if (m_valid) begin
      m_data = rec[int'(idx_q)*CHUNK_W +: CHUNK_W];
      m_last = (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (!empty) state_d = HDR;
      HDR: begin
        if (hs) begin
          state_d = DATA;
          idx_d   = IDX_W'(1);
        end
      end
      DATA: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (count_d != '0) ? HDR : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= CNT_RST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_q + 32'd1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cnt_q, cap_data};
  end

endmodule
